game_flow_ctrl: RTL

- Central sequencer for one round of the rhythm/Pac-Man game.
- Replaces the ad-hoc combinational start/song gating at top level with a registered state machine.
- Latches the song choice, then runs a countdown and enables note generation, audio and keypad scanning.
- Tracks misses/lives and score target, then ends the round in WIN or LOSE; drives status LEDs and a one-cycle score-clear pulse.

---
 rtl/game_flow_ctrl_pkg.sv | 39 +++
 rtl/game_flow_ctrl_edge_pulse.sv | 28 ++
 rtl/game_flow_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/game_flow_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl_pkg
// Description : Shared constants for the game round sequencer: state
//               encodings, default round parameters and song indices.
// Revision    : 1.0 - initial release
// ============================================================================
package game_flow_ctrl_pkg;

    // Round state encoding, also presented on state_o for the LCD
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_arm   = 3'd1;
    localparam logic [2:0] c_st_count = 3'd2;
    localparam logic [2:0] c_st_play  = 3'd3;
    localparam logic [2:0] c_st_win   = 3'd4;
    localparam logic [2:0] c_st_lose  = 3'd5;

    // Default round parameters
    localparam int          c_cnt_ticks_default = 3000;
    localparam int          c_lives_default     = 3;
    localparam logic [15:0] c_win_score_default = 16'h0100;
    localparam int          c_songs_default     = 2;

    // Song indices
    localparam logic [1:0] c_song0 = 2'd0;
    localparam logic [1:0] c_song1 = 2'd1;

    // Blink period: led[0] toggles every 250 ticks (2 Hz from 1 kHz)
    localparam logic [7:0] c_blink_last = 8'd249;

    // One-hot song indicator for the LEDs, {song1, song0}
    function automatic logic [1:0] song_onehot(input logic [1:0] idx);
        song_onehot = 2'b00;
        if (idx == c_song0) song_onehot = 2'b01;
        if (idx == c_song1) song_onehot = 2'b10;
    endfunction

endpackage : game_flow_ctrl_pkg
`default_nettype wire

// File: rtl/game_flow_ctrl_edge_pulse.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl_edge_pulse
// Description : Rising/falling edge detector for an already synchronised
//               level input, using a registered previous value.
// Revision    : 1.0 - initial release
// ============================================================================
module game_flow_ctrl_edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    // Remember last cycle's level so edges show up as one-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prev <= 1'b0;
        else     r_prev <= i_sig;
    end

    assign o_rise = i_sig & ~r_prev;
    assign o_fall = ~i_sig & r_prev;

endmodule : game_flow_ctrl_edge_pulse
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl
// Description : Round sequencer for the rhythm game. Latches the song,
//               runs a countdown, gates play, tracks lives and score and
//               ends the round in WIN or LOSE.
// Revision    : 1.0 - initial release
// ============================================================================
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int          CNT_TICKS = c_cnt_ticks_default,
    parameter int          LIVES     = c_lives_default,
    parameter logic [15:0] WIN_SCORE = c_win_score_default,
    parameter int          SONGS     = c_songs_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1k,
    input  logic        start_sw,
    input  logic [1:0]  song_sel,
    input  logic        hit_p,
    input  logic        miss_p,
    input  logic        song_end_p,
    input  logic [15:0] score_bcd,
    output logic        play_en,
    output logic [1:0]  song,
    output logic        score_clr,
    output logic [2:0]  lives,
    output logic [2:0]  state_o,
    output logic [2:0]  led
);

    localparam int             c_cw       = (CNT_TICKS > 1) ? $clog2(CNT_TICKS) : 1;
    localparam logic [c_cw-1:0] c_cnt_load = c_cw'(CNT_TICKS - 1);
    localparam logic [2:0]     c_lives    = 3'(LIVES);
    localparam logic           c_song1_en = (SONGS > 1);

    logic [2:0]      r_state, w_state_nxt;
    logic [c_cw-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_lives, w_lives_nxt;
    logic [1:0]      r_song, w_song_nxt;
    logic            r_song_valid, w_song_valid_nxt;
    logic            r_play_en;
    logic [7:0]      r_blink_cnt;
    logic            r_blink;
    logic [7:0]      r_hit_cnt;

    logic            w_start_rise, w_start_fall;
    logic            w_sel_valid;
    logic [1:0]      w_sel_idx;
    logic [2:0]      w_lives_dec;
    logic            w_led0;
    logic            w_endgame;

    game_flow_ctrl_edge_pulse u_start_edge (
        .clk    (clk),
        .rst    (reset),
        .i_sig  (start_sw),
        .o_rise (w_start_rise),
        .o_fall (w_start_fall)
    );

    // bit0 wins when both selects are set; song 1 only exists if configured
    assign w_sel_valid = song_sel[0] | (song_sel[1] & c_song1_en);
    assign w_sel_idx   = song_sel[0] ? c_song0 : c_song1;
    assign w_lives_dec = (r_lives != 3'd0) ? (r_lives - 3'd1) : 3'd0;
    assign w_endgame   = (r_state == c_st_win) || (r_state == c_st_lose);

    // Round control: next state and next values of the round registers
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_lives_nxt      = r_lives;
        w_song_nxt       = r_song;
        w_song_valid_nxt = r_song_valid;
        case (r_state)
            c_st_idle: begin
                if (w_sel_valid) begin
                    w_song_nxt       = w_sel_idx;
                    w_song_valid_nxt = 1'b1;
                end
                if (w_start_rise) w_state_nxt = c_st_arm;
            end
            c_st_arm: begin
                w_lives_nxt = c_lives;
                w_cnt_nxt   = c_cnt_load;
                w_state_nxt = c_st_count;
            end
            c_st_count: begin
                if (tick_1k) begin
                    if (r_cnt == '0) w_state_nxt = c_st_play;
                    else             w_cnt_nxt   = r_cnt - c_cw'(1);
                end
            end
            c_st_play: begin
                if (miss_p) w_lives_nxt = w_lives_dec;
                // Valid BCD orders the same as binary, so a plain compare works
                if (miss_p && (r_lives <= 3'd1))
                    w_state_nxt = c_st_lose;
                else if ((score_bcd >= WIN_SCORE) || (song_end_p && (r_lives != 3'd0)))
                    w_state_nxt = c_st_win;
            end
            c_st_win, c_st_lose: begin
                w_state_nxt = r_state;
            end
            default: w_state_nxt = c_st_idle;
        endcase
        // Releasing start aborts any round; lives and song survive the abort
        if ((r_state != c_st_idle) && w_start_fall) begin
            w_state_nxt = c_st_idle;
            w_lives_nxt = r_lives;
            w_cnt_nxt   = r_cnt;
        end
    end

    // Round registers; play_en is registered from the next state so it
    // follows PLAY exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_lives      <= c_lives;
            r_song       <= c_song0;
            r_song_valid <= 1'b0;
            r_play_en    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_lives      <= w_lives_nxt;
            r_song       <= w_song_nxt;
            r_song_valid <= w_song_valid_nxt;
            r_play_en    <= (w_state_nxt == c_st_play);
        end
    end

    // 2 Hz blink of the status LED while a finished round is displayed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= 8'd0;
            r_blink     <= 1'b1;
        end else if (!w_endgame) begin
            r_blink_cnt <= 8'd0;
            r_blink     <= 1'b1;
        end else if (tick_1k) begin
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt <= 8'd0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end

    // Saturating hit counter, kept as a debug register only
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           r_hit_cnt <= 8'd0;
        else if (hit_p && (r_hit_cnt != 8'hFF)) r_hit_cnt <= r_hit_cnt + 8'd1;
    end

    // Running LED: solid in IDLE, blinking after a round, dark while playing
    always_comb begin
        w_led0 = 1'b0;
        if (r_state == c_st_idle) w_led0 = 1'b1;
        else if (w_endgame)       w_led0 = r_blink;
    end

    // Song LEDs stay dark until a song has actually been chosen after reset
    assign led       = {(r_song_valid ? song_onehot(r_song) : 2'b00), w_led0};
    assign play_en   = r_play_en;
    assign song      = r_song;
    assign score_clr = (r_state == c_st_arm);
    assign lives     = r_lives;
    assign state_o   = r_state;

endmodule : game_flow_ctrl
`default_nettype wire
